reduce_gate_db: RTL and testbench
=================================

REDUCE_GATE_DB -- requirements
Module: reduce_gate_db

Interface
REQ-001 The block SHALL have parameter N, default 4, giving the number of input channels (legal range 2..8).
REQ-002 The block SHALL have parameter DEB_CYCLES, default 4, giving the stable-cycle count for debounce (legal range 1..255).
REQ-003 The block SHALL have port clk, input, 1 bit, the single system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rstn, input, 1 bit; reset is synchronous and active-low.
REQ-005 The block SHALL have port en, input, 1 bit; when high, the output register updates.
REQ-006 The block SHALL have port op, input, 3 bits, selecting the reduction: 000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR; 110 and 111 force constant 0.
REQ-007 The block SHALL have port mask, input, N bits; a 1 bit includes that channel in the reduction.
REQ-008 The block SHALL have port x, input, N bits, the raw asynchronous channel inputs (buttons/switches).
REQ-009 The block SHALL have port xs, output, N bits, the debounced channel levels.
REQ-010 The block SHALL have port z, output, 1 bit, the registered reduction result.
REQ-011 The block SHALL have port chg, output, 1 bit, a one-cycle pulse that is high in the cycle z takes a new value.

Function
REQ-012 Each channel SHALL pass x[i] through a 2-flop synchronizer (s1, s2) before debounce.
REQ-013 Each channel SHALL keep a counter that clears whenever s2 equals xs[i] and increments whenever s2 differs from xs[i].
REQ-014 xs[i] SHALL take the value of s2 on the DEB_CYCLES-th consecutive edge at which s2 differs from xs[i]; the counter clears on that same edge.
REQ-015 Any s2 excursion shorter than DEB_CYCLES cycles SHALL leave xs[i] unchanged.
REQ-016 Let edge k be the first edge to sample a new stable x level. xs SHALL update at edge k+DEB_CYCLES+1, and z (with en=1) SHALL update at edge k+DEB_CYCLES+2.
REQ-017 Masked-out channels SHALL contribute the identity of the selected op: 1 for AND/NAND, 0 for OR/NOR/XOR/XNOR.
REQ-018 With mask all-zero, z SHALL equal the op's empty reduction: AND 1, OR 0, XOR 0, NAND 0, NOR 1, XNOR 1.
REQ-019 A change of op or mask with en=1 SHALL be reflected in z at the next edge (one-cycle latency).
REQ-020 With en=0, z SHALL hold, and chg SHALL be 0.
REQ-021 Synchronizers and debounce SHALL keep running regardless of en.
REQ-022 When en rises, z SHALL load the current reduction at the next edge; chg pulses only if the value differs.
REQ-023 chg SHALL be 1 for exactly one cycle per z transition.
REQ-024 chg SHALL stay 0 when z is reloaded with an unchanged value.
REQ-025 Debounce counters SHALL saturate-safe: counter width is ceil(log2(DEB_CYCLES+1)) and the counter never wraps.

Reset
REQ-026 When rstn=0 at an edge, s1, s2, xs, counters, z and chg SHALL all become 0, regardless of en or op.
REQ-027 Reset asserted mid-debounce SHALL discard the partial count; xs stays 0 until a fresh full DEB_CYCLES qualification.
REQ-028 At the first edge after reset release with en=1, z SHALL load the reduction of xs=0. Example: op=NOR gives z=1 and chg=1.

Structure
REQ-029 Op encodings and the identity/empty-reduction table SHALL live in the shared package gate_pkg.
REQ-030 The per-channel synchronizer plus debounce SHALL be a sub-module db_chan with parameter DEB_CYCLES, instantiated N times.
REQ-031 The reduction and the output register SHALL stay in reduce_gate_db.

Verification
REQ-032 Reset test: N=4, DEB_CYCLES=4, op=OR, mask=1111, x=0000, rstn low 3 cycles then high -> z=0, chg=0, xs=0000 throughout.
REQ-033 Latency test: op=OR, x[2] rises before edge k and stays high -> xs=0100 at edge k+5; z=1 with chg=1 at edge k+6 only.
REQ-034 Glitch rejection: x[0] high for 3 cycles, DEB_CYCLES=4 -> xs[0] stays 0, z unchanged, chg never asserted.
REQ-035 Op/mask sweep: xs=1011 stable, mask=1111, step op 000..111 one per cycle -> z sequence 0,1,1,1,0,0,0,0; then mask=0000, op=NOR -> z=1.
REQ-036 Enable hold: en=0 while x[1] debounces high under op=XOR, then en=1 -> z holds old value, then updates one edge after en rises with a single chg pulse.
REQ-037 Reset mid-debounce: x[3] high, rstn pulsed low 2 edges after xs-count begins -> xs[3] rises 4 qualifying edges after reset release, not earlier.

Source files
------------

// File: rtl/gate_pkg.sv
// rtl/gate_pkg.sv - shared op encodings and identity/empty-reduction tables
package gate_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_AND   = 3'b000,
        OP_OR    = 3'b001,
        OP_XOR   = 3'b010,
        OP_NAND  = 3'b011,
        OP_NOR   = 3'b100,
        OP_XNOR  = 3'b101,
        OP_ZERO0 = 3'b110,
        OP_ZERO1 = 3'b111
    } op_e;

    // Value a masked-out channel contributes so it cannot affect the result.
    function automatic logic op_identity(input logic [OP_W-1:0] op);
        return (op == OP_AND) || (op == OP_NAND);
    endfunction

    // Result of reducing over zero channels.
    function automatic logic op_empty(input logic [OP_W-1:0] op);
        case (op)
            OP_AND, OP_NOR, OP_XNOR: return 1'b1;
            default:                 return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/db_chan.sv
// rtl/db_chan.sv - one channel: 2-flop synchronizer followed by debounce
//
// Ports:
//   clk, rstn : clock, synchronous active-low reset
//   x_i       : raw asynchronous input
//   xs_o      : debounced level
module db_chan #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rstn,
    input  logic x_i,
    output logic xs_o
);

    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic          s1_q, s1_d;
    logic          s2_q, s2_d;
    logic          xs_q, xs_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        s1_d  = x_i;
        s2_d  = s1_q;
        xs_d  = xs_q;
        cnt_d = '0;
        if (s2_q != xs_q) begin
            // The DEB_CYCLES-th consecutive mismatch commits the new level;
            // the counter therefore never exceeds DEB_CYCLES-1.
            if (cnt_q == CW'(DEB_CYCLES - 1)) begin
                xs_d = s2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            s1_q  <= 1'b0;
            s2_q  <= 1'b0;
            xs_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            s1_q  <= s1_d;
            s2_q  <= s2_d;
            xs_q  <= xs_d;
            cnt_q <= cnt_d;
        end
    end

    assign xs_o = xs_q;

endmodule

// File: rtl/reduce_gate_db.sv
// rtl/reduce_gate_db.sv - debounced N-channel masked reduction with change pulse
//
// Ports:
//   clk, rstn : clock, synchronous active-low reset
//   en        : output register update enable
//   op        : reduction select (AND/OR/XOR/NAND/NOR/XNOR, 11x -> 0)
//   mask      : per-channel include bits
//   x         : raw channel inputs
//   xs        : debounced channel levels
//   z         : registered reduction result
//   chg       : one-cycle pulse when z changes
module reduce_gate_db
    import gate_pkg::*;
#(
    parameter int N          = 4,
    parameter int DEB_CYCLES = 4
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            en,
    input  logic [OP_W-1:0] op,
    input  logic [N-1:0]    mask,
    input  logic [N-1:0]    x,
    output logic [N-1:0]    xs,
    output logic            z,
    output logic            chg
);

    logic [N-1:0] masked;
    logic         red;
    logic         z_q, z_d;
    logic         chg_q, chg_d;

    for (genvar i = 0; i < N; i++) begin : g_chan
        db_chan #(.DEB_CYCLES(DEB_CYCLES)) u_chan (
            .clk  (clk),
            .rstn (rstn),
            .x_i  (x[i]),
            .xs_o (xs[i])
        );
    end

    always_comb begin
        // Excluded channels take the op's identity so they are transparent.
        masked = (xs & mask) | (~mask & {N{op_identity(op)}});
        case (op)
            OP_AND:  red = &masked;
            OP_OR:   red = |masked;
            OP_XOR:  red = ^masked;
            OP_NAND: red = ~&masked;
            OP_NOR:  red = ~|masked;
            OP_XNOR: red = ~^masked;
            default: red = 1'b0;
        endcase
        if (mask == '0) begin
            red = op_empty(op);
        end
    end

    always_comb begin
        z_d   = z_q;
        chg_d = 1'b0;
        if (en) begin
            z_d   = red;
            chg_d = (red != z_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            z_q   <= 1'b0;
            chg_q <= 1'b0;
        end else begin
            z_q   <= z_d;
            chg_q <= chg_d;
        end
    end

    assign z   = z_q;
    assign chg = chg_q;

endmodule

// File: tb/tb_reduce_gate_db.sv
// tb/tb_reduce_gate_db.sv - self-checking bench for reduce_gate_db
module tb_reduce_gate_db;

    localparam int N   = 4;
    localparam int DEB = 4;

    logic         clk = 1'b0;
    logic         rstn;
    logic         en;
    logic [2:0]   op;
    logic [N-1:0] mask;
    logic [N-1:0] x;
    logic [N-1:0] xs;
    logic         z;
    logic         chg;

    int checks   = 0;
    int failures = 0;
    bit cmp_on   = 1'b0;

    reduce_gate_db #(.N(N), .DEB_CYCLES(DEB)) dut (
        .clk  (clk),
        .rstn (rstn),
        .en   (en),
        .op   (op),
        .mask (mask),
        .x    (x),
        .xs   (xs),
        .z    (z),
        .chg  (chg)
    );

    always #5 clk = ~clk;

    // Model: x reaches s2 two edges late; a level is accepted once the last
    // DEB samples of s2 all disagree with the current debounced level.
    logic [N-1:0]   s1_m, s2_m, xs_m;
    logic [DEB-1:0] hist_m [N];
    logic           z_m, chg_m;

    function automatic logic model_reduce(input logic [2:0] o, input logic [N-1:0] m,
                                          input logic [N-1:0] v);
        int sel, ones;
        logic r;
        sel  = 0;
        ones = 0;
        for (int i = 0; i < N; i++) begin
            if (m[i]) begin
                sel++;
                if (v[i]) ones++;
            end
        end
        case (o)
            3'd0: r = (ones == sel);
            3'd1: r = (ones > 0);
            3'd2: r = (ones % 2) == 1;
            3'd3: r = !(ones == sel);
            3'd4: r = !(ones > 0);
            3'd5: r = !((ones % 2) == 1);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    always @(posedge clk) begin
        logic nz;
        if (!rstn) begin
            s1_m  = '0;
            s2_m  = '0;
            xs_m  = '0;
            z_m   = 1'b0;
            chg_m = 1'b0;
            for (int i = 0; i < N; i++) hist_m[i] = '0;
        end else begin
            nz    = en ? model_reduce(op, mask, xs_m) : z_m;
            chg_m = en && (nz != z_m);
            z_m   = nz;
            for (int i = 0; i < N; i++) begin
                hist_m[i] = {hist_m[i][DEB-2:0], s2_m[i]};
                if (hist_m[i] == {DEB{~xs_m[i]}}) xs_m[i] = ~xs_m[i];
            end
            s2_m = s1_m;
            s1_m = x;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_on) begin
            check("model_xs", 32'(xs), 32'(xs_m));
            check("model_z", 32'(z), 32'(z_m));
            check("model_chg", 32'(chg), 32'(chg_m));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        logic [7:0] sweep_exp;
        sweep_exp = 8'b0000_1110;   // bit k = expected z for op k on xs=1011
        rstn = 1'b0; en = 1'b1; op = 3'd1; mask = 4'b1111; x = 4'b0000;
        cmp_on = 1'b1;

        // Reset phase and quiet operation after release
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_xs", 32'(xs), 32'h0);
            check("rst_z", 32'(z), 32'h0);
            check("rst_chg", 32'(chg), 32'h0);
        end
        rstn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("post_rst_z", 32'(z), 32'h0);
            check("post_rst_chg", 32'(chg), 32'h0);
            check("post_rst_xs", 32'(xs), 32'h0);
        end

        // Latency: edge k is the first tick after x changes
        x = 4'b0100;
        settle(5);
        check("lat_xs_k4", 32'(xs), 32'h0);
        tick();
        check("lat_xs_k5", 32'(xs), 32'h4);
        check("lat_z_k5", 32'(z), 32'h0);
        tick();
        check("lat_z_k6", 32'(z), 32'h1);
        check("lat_chg_k6", 32'(chg), 32'h1);
        tick();
        check("lat_chg_k7", 32'(chg), 32'h0);

        // Glitch of three cycles on x[0]
        x = 4'b0101;
        settle(3);
        x = 4'b0100;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("glitch_xs", 32'(xs), 32'h4);
            check("glitch_chg", 32'(chg), 32'h0);
        end

        // Op sweep on xs=1011
        x = 4'b1011;
        settle(8);
        check("sweep_xs", 32'(xs), 32'hB);
        for (int k = 0; k < 8; k++) begin
            op = 3'(k);
            tick();
            check($sformatf("sweep_op%0d", k), 32'(z), 32'(sweep_exp[k]));
        end
        mask = 4'b0000; op = 3'd4;
        tick();
        check("empty_nor", 32'(z), 32'h1);
        mask = 4'b1010; op = 3'd0;
        tick();
        check("masked_and", 32'(z), 32'h1);

        // Enable hold under XOR
        mask = 4'b1111; op = 3'd2; x = 4'b1001;
        settle(8);
        check("en_pre_z", 32'(z), 32'h0);
        en = 1'b0; x = 4'b1011;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("en_hold_z", 32'(z), 32'h0);
            check("en_hold_chg", 32'(chg), 32'h0);
        end
        check("en_hold_xs", 32'(xs), 32'hB);
        en = 1'b1;
        tick();
        check("en_rise_z", 32'(z), 32'h1);
        check("en_rise_chg", 32'(chg), 32'h1);
        tick();
        check("en_rise_chg2", 32'(chg), 32'h0);

        // Reset mid-debounce, then reload under NOR
        x = 4'b0000;
        settle(8);
        x = 4'b1000;
        settle(3);              // edges k, k+1 (s2), k+2 (count starts)
        rstn = 1'b0; op = 3'd4;
        settle(2);
        check("mid_rst_xs", 32'(xs), 32'h0);
        rstn = 1'b1;
        tick();
        check("rel_nor_z", 32'(z), 32'h1);
        check("rel_nor_chg", 32'(chg), 32'h1);
        settle(4);
        check("mid_rst_xs_r5", 32'(xs), 32'h0);
        tick();
        check("mid_rst_xs_r6", 32'(xs), 32'h8);
        tick();
        check("mid_rst_z", 32'(z), 32'h0);
        check("mid_rst_chg", 32'(chg), 32'h1);
        settle(2);

        cmp_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
